// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - WIDTH-bit ALU with operand conditioning, shift-add multiply and valid/ready handshake
module alu_seq #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_inv,
  input  logic             b_inv,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   a_c;
  logic [WIDTH-1:0]   b_c;
  logic [WIDTH:0]     sum_w;
  logic               add_ovf;
  logic               is_mul;
  logic               accept;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_cout;
  logic               sc_ovf;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;

  // Conditioned operands and the shared adder used by ADD and SLT
  assign a_c     = a_inv ? ~a : a;
  assign b_c     = b_inv ? ~b : b;
  assign sum_w   = {1'b0, a_c} + {1'b0, b_c} + {{WIDTH{1'b0}}, cin};
  assign add_ovf = (a_c[WIDTH-1] == b_c[WIDTH-1]) & (sum_w[WIDTH-1] != a_c[WIDTH-1]);

  // With MUL disabled the MUL code falls through to the reserved single-cycle path
  assign is_mul = (op == OP_MUL) & (MUL_EN != 1'b0);

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (acc LSB) is set, then shift the whole accumulator right
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Single-cycle operation results, including reserved codes
  always_comb begin
    sc_result = '0;
    sc_cout   = 1'b0;
    sc_ovf    = 1'b0;
    case (op)
      OP_AND: sc_result = a_c & b_c;
      OP_OR:  sc_result = a_c | b_c;
      OP_ADD: begin
        sc_result = sum_w[WIDTH-1:0];
        sc_cout   = sum_w[WIDTH];
        sc_ovf    = add_ovf;
      end
      OP_SLT: begin
        sc_result = {{(WIDTH-1){1'b0}}, sum_w[WIDTH-1] ^ add_ovf};
        sc_cout   = sum_w[WIDTH];
        sc_ovf    = add_ovf;
      end
      default: begin
        sc_result = '0;
        sc_cout   = 1'b0;
        sc_ovf    = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update: accept, multiply iteration, drain
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
        if (accept) begin
          if (is_mul) begin
            state_d = BUSY;
            acc_d   = {{WIDTH{1'b0}}, b_c};
            mcand_d = a_c;
            cnt_d   = '0;
          end else begin
            state_d  = DONE;
            result_d = sc_result;
            zero_d   = (sc_result == '0);
            cout_d   = sc_cout;
            ovf_d    = sc_ovf;
          end
        end
      end
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = acc_step[WIDTH-1:0];
          zero_d   = (acc_step[WIDTH-1:0] == '0);
          cout_d   = 1'b0;
          ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any multiply in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
